// File: rtl/tl_ctrl.sv
// Traffic-light controller for a two-way junction.
//
// Runs the normal cycle ALLRED_A -> NS_GREEN -> NS_YELLOW -> ALLRED_B -> EW_GREEN -> EW_YELLOW,
// with each phase lasting its *_TICKS parameter in clk cycles. A flash mode request
// ({y,z} = 01 yellow, 10 red) is honoured only at the end of an all-red clearance. While
// flashing, both directions blink the requested colour: lit for FLASH_TICKS cycles, then dark
// for FLASH_TICKS cycles.
//
// Optional feature (macro TL_PED_EN): a ped_req pulse latches a sticky request. At the end
// of ALLRED_B, a latched request inserts a pedestrian phase. That phase holds all reds with
// walk=1 for GREEN_TICKS cycles, then continues to EW_GREEN.
//
// Ports:
//   clk            sole clock, rising edge
//   rst            asynchronous active-low reset
//   y, z           mode code, registered before use (one cycle latency)
//   ns_r/ns_y/ns_g north-south lamps, registered
//   ew_r/ew_y/ew_g east-west lamps, registered
//   ped_req        (TL_PED_EN only) pedestrian request pulse
//   walk           (TL_PED_EN only) walk lamp, registered
module tl_ctrl #(
  parameter int unsigned GREEN_TICKS  = 8,
  parameter int unsigned YELLOW_TICKS = 3,
  parameter int unsigned ALLRED_TICKS = 2,
  parameter int unsigned FLASH_TICKS  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic y,
  input  logic z,
`ifdef TL_PED_EN
  input  logic ped_req,
  output logic walk,
`endif
  output logic ns_r,
  output logic ns_y,
  output logic ns_g,
  output logic ew_r,
  output logic ew_y,
  output logic ew_g
);

  localparam logic [15:0] GreenLoad  = 16'(GREEN_TICKS - 1);
  localparam logic [15:0] YellowLoad = 16'(YELLOW_TICKS - 1);
  localparam logic [15:0] AllRedLoad = 16'(ALLRED_TICKS - 1);
  localparam logic [15:0] FlashLoad  = 16'(FLASH_TICKS - 1);

  // Lamp vector order: {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}
  localparam logic [5:0] LampAllRed   = 6'b100_100;
  localparam logic [5:0] LampNsGreen  = 6'b001_100;
  localparam logic [5:0] LampNsYellow = 6'b010_100;
  localparam logic [5:0] LampEwGreen  = 6'b100_001;
  localparam logic [5:0] LampEwYellow = 6'b100_010;
  localparam logic [5:0] LampFlashYel = 6'b010_010;

  typedef enum logic [2:0] {
    StAllRedA,
    StNsGreen,
    StNsYellow,
    StAllRedB,
    StEwGreen,
    StEwYellow,
    StFlash
`ifdef TL_PED_EN
    , StPed
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  mode_q;
  logic        lit_q, lit_d;
  logic [5:0]  lamps_q, lamps_d;
  logic        flash_req;
  logic        cnt_zero;
`ifdef TL_PED_EN
  logic        ped_flag_q, ped_flag_d;
  logic        walk_q, walk_d;
`endif

  // 11 is deliberately not a flash code; it behaves like normal mode.
  assign flash_req = (mode_q == 2'b01) || (mode_q == 2'b10);
  assign cnt_zero  = (cnt_q == 16'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 16'd1;
    lit_d   = lit_q;
`ifdef TL_PED_EN
    ped_flag_d = ped_flag_q | ped_req;
`endif
    case (state_q)
      StAllRedA: begin
        if (cnt_zero) begin
          if (flash_req) begin
            state_d = StFlash;
            cnt_d   = FlashLoad;
            lit_d   = 1'b1;
          end else begin
            state_d = StNsGreen;
            cnt_d   = GreenLoad;
          end
        end
      end
      StNsGreen: begin
        if (cnt_zero) begin
          state_d = StNsYellow;
          cnt_d   = YellowLoad;
        end
      end
      StNsYellow: begin
        if (cnt_zero) begin
          state_d = StAllRedB;
          cnt_d   = AllRedLoad;
        end
      end
      StAllRedB: begin
        if (cnt_zero) begin
          // Flash wins over a pending pedestrian request, which stays latched.
          if (flash_req) begin
            state_d = StFlash;
            cnt_d   = FlashLoad;
            lit_d   = 1'b1;
`ifdef TL_PED_EN
          end else if (ped_flag_q) begin
            state_d    = StPed;
            cnt_d      = GreenLoad;
            ped_flag_d = ped_req;
`endif
          end else begin
            state_d = StEwGreen;
            cnt_d   = GreenLoad;
          end
        end
      end
      StEwGreen: begin
        if (cnt_zero) begin
          state_d = StEwYellow;
          cnt_d   = YellowLoad;
        end
      end
      StEwYellow: begin
        if (cnt_zero) begin
          state_d = StAllRedA;
          cnt_d   = AllRedLoad;
        end
      end
      StFlash: begin
        if (!flash_req) begin
          state_d = StAllRedA;
          cnt_d   = AllRedLoad;
        end else if (cnt_zero) begin
          // A colour change between 01 and 10 leaves the blink phase running.
          lit_d = ~lit_q;
          cnt_d = FlashLoad;
        end
      end
`ifdef TL_PED_EN
      StPed: begin
        if (cnt_zero) begin
          state_d = StEwGreen;
          cnt_d   = GreenLoad;
        end
      end
`endif
      default: begin
        state_d = StAllRedA;
        cnt_d   = AllRedLoad;
      end
    endcase

    // Lamps are decoded from the next state so the registered outputs track state_q.
    lamps_d = LampAllRed;
    case (state_d)
      StNsGreen:  lamps_d = LampNsGreen;
      StNsYellow: lamps_d = LampNsYellow;
      StEwGreen:  lamps_d = LampEwGreen;
      StEwYellow: lamps_d = LampEwYellow;
      StFlash: begin
        if (!lit_d) begin
          lamps_d = 6'b000_000;
        end else if (mode_q == 2'b01) begin
          lamps_d = LampFlashYel;
        end else begin
          lamps_d = LampAllRed;
        end
      end
      default: lamps_d = LampAllRed;
    endcase
`ifdef TL_PED_EN
    walk_d = (state_d == StPed);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StAllRedA;
      cnt_q   <= AllRedLoad;
      mode_q  <= 2'b00;
      lit_q   <= 1'b1;
      lamps_q <= LampAllRed;
`ifdef TL_PED_EN
      ped_flag_q <= 1'b0;
      walk_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= {y, z};
      lit_q   <= lit_d;
      lamps_q <= lamps_d;
`ifdef TL_PED_EN
      ped_flag_q <= ped_flag_d;
      walk_q     <= walk_d;
`endif
    end
  end

  assign {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g} = lamps_q;
`ifdef TL_PED_EN
  assign walk = walk_q;
`endif

endmodule

// File: tb/tb_tl_ctrl.sv
// Self-checking bench for tl_ctrl (default parameters).
// The reference model tracks which phase of the signal plan is active. It also tracks how many
// cycles of that phase have elapsed. Expected lamps are derived from the phase.
// Define TL_PED_EN for both bench and RTL to cover the pedestrian phase.
module tb_tl_ctrl;

  localparam int GT = 8;
  localparam int YT = 3;
  localparam int AT = 2;
  localparam int FT = 4;

  // Phase codes of the reference plan
  localparam int PH_ARA   = 0;
  localparam int PH_NSG   = 1;
  localparam int PH_NSY   = 2;
  localparam int PH_ARB   = 3;
  localparam int PH_EWG   = 4;
  localparam int PH_EWY   = 5;
  localparam int PH_FLASH = 6;
  localparam int PH_PED   = 7;

  localparam logic [6:0] ALL_RED = 7'b0_100_100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic y = 1'b0;
  logic z = 1'b0;
  logic ped_req = 1'b0;
  logic walk;
  logic ns_r, ns_y, ns_g, ew_r, ew_y, ew_g;
  logic [6:0] obs;

  int total = 0;
  int bad = 0;

  // Reference model state
  int         m_phase;
  int         m_elapsed;
  int         m_flash_t;
  logic [1:0] m_mode;
  bit         m_flag;
  logic [6:0] m_exp;

  always #5 clk = ~clk;

  tl_ctrl #(
    .GREEN_TICKS (GT),
    .YELLOW_TICKS(YT),
    .ALLRED_TICKS(AT),
    .FLASH_TICKS (FT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .y      (y),
    .z      (z),
`ifdef TL_PED_EN
    .ped_req(ped_req),
    .walk   (walk),
`endif
    .ns_r   (ns_r),
    .ns_y   (ns_y),
    .ns_g   (ns_g),
    .ew_r   (ew_r),
    .ew_y   (ew_y),
    .ew_g   (ew_g)
  );

`ifndef TL_PED_EN
  assign walk = 1'b0;
`endif

  assign obs = {walk, ns_r, ns_y, ns_g, ew_r, ew_y, ew_g};

  function automatic int dur(input int ph);
    case (ph)
      PH_ARA, PH_ARB:         return AT;
      PH_NSG, PH_EWG, PH_PED: return GT;
      default:                return YT;
    endcase
  endfunction

  function automatic logic [6:0] lamps_of(input int ph, input int ft, input logic [1:0] md);
    case (ph)
      PH_NSG: return 7'b0_001_100;
      PH_NSY: return 7'b0_010_100;
      PH_EWG: return 7'b0_100_001;
      PH_EWY: return 7'b0_100_010;
      PH_PED: return 7'b1_100_100;
      PH_FLASH: begin
        if (((ft / FT) % 2) != 0) return 7'b0_000_000;
        if (md == 2'b01) return 7'b0_010_010;
        return ALL_RED;
      end
      default: return ALL_RED;
    endcase
  endfunction

  task automatic model_reset();
    m_phase   = PH_ARA;
    m_elapsed = 0;
    m_flash_t = 0;
    m_mode    = 2'b00;
    m_flag    = 1'b0;
    m_exp     = ALL_RED;
  endtask

  // One clock edge: advance the model using the mode seen on the previous edge.
  task automatic step();
    logic [1:0] dm;
    bit fl;
    bit preq;
    bit took_ped;
    @(posedge clk);
    dm = m_mode;
    preq = ped_req;
    took_ped = 1'b0;
    fl = (dm == 2'b01) || (dm == 2'b10);
    if (m_phase == PH_FLASH) begin
      if (!fl) begin
        m_phase   = PH_ARA;
        m_elapsed = 0;
      end else begin
        m_flash_t++;
      end
    end else begin
      m_elapsed++;
      if (m_elapsed == dur(m_phase)) begin
        m_elapsed = 0;
        if ((m_phase == PH_ARA || m_phase == PH_ARB) && fl) begin
          m_phase   = PH_FLASH;
          m_flash_t = 0;
        end else if (m_phase == PH_ARB && m_flag) begin
          m_phase  = PH_PED;
          took_ped = 1'b1;
        end else if (m_phase == PH_PED) begin
          m_phase = PH_EWG;
        end else begin
          m_phase = (m_phase + 1) % 6;
        end
      end
    end
    if (took_ped) m_flag = 1'b0;
    m_flag = m_flag | preq;
    m_mode = {y, z};
    m_exp  = lamps_of(m_phase, m_flash_t, dm);
    #1;
  endtask

  // Assert reset 'pre' time units from now, hold across two edges, release away from an edge.
  task automatic apply_reset(input int pre, input string tag);
    #(pre);
    rst = 1'b0;
    #1;
    model_reset();
    total++;
    if (obs !== ALL_RED) begin
      bad++;
      $display("FAIL %s_immediate got=%b want=%b", tag, obs, ALL_RED);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs !== ALL_RED) begin
      bad++;
      $display("FAIL %s_held got=%b want=%b", tag, obs, ALL_RED);
    end
    rst = 1'b1;
  endtask

  task automatic test_reset();
    y = 1'b0;
    z = 1'b0;
    apply_reset(2, "reset");
  endtask

  task automatic test_normal();
    int ng = 0;
    int ewy = 0;
    int first_g = 0;
    y = 1'b0;
    z = 1'b0;
    apply_reset(0, "normal_rst");
    for (int i = 1; i <= 60; i++) begin
      step();
      total++;
      if (obs !== m_exp) begin
        bad++;
        $display("FAIL normal edge=%0d got=%b want=%b", i, obs, m_exp);
      end
      if (i <= 26) begin
        ng += int'(ns_g);
        ewy += int'(ew_y);
        if (ns_g === 1'b1 && first_g == 0) first_g = i;
      end
    end
    total++;
    if (first_g != 2) begin
      bad++;
      $display("FAIL normal_first_green got=%0d want=2", first_g);
    end
    total++;
    if (ng != GT) begin
      bad++;
      $display("FAIL normal_green_len got=%0d want=%0d", ng, GT);
    end
    total++;
    if (ewy != YT) begin
      bad++;
      $display("FAIL normal_ew_yellow_len got=%0d want=%0d", ewy, YT);
    end
  endtask

  task automatic test_mode11();
    y = 1'b1;
    z = 1'b1;
    apply_reset(0, "mode11_rst");
    for (int i = 1; i <= 60; i++) begin
      step();
      total++;
      if (obs !== m_exp) begin
        bad++;
        $display("FAIL mode11 edge=%0d got=%b want=%b", i, obs, m_exp);
      end
    end
  endtask

  task automatic test_flash();
    int n = 0;
    y = 1'b0;
    z = 1'b0;
    apply_reset(0, "flash_rst");
    while (!(m_phase == PH_NSG && m_elapsed == 2) && n < 100) begin
      step();
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL flash_reach_nsg got=%0d want<100", n);
    end
    {y, z} = 2'b01;
    for (int i = 0; i < 40; i++) begin
      step();
      total++;
      if (obs !== m_exp) begin
        bad++;
        $display("FAIL flash_yellow i=%0d got=%b want=%b", i, obs, m_exp);
      end
    end
    {y, z} = 2'b10;
    for (int i = 0; i < 12; i++) begin
      step();
      total++;
      if (obs !== m_exp) begin
        bad++;
        $display("FAIL flash_red i=%0d got=%b want=%b", i, obs, m_exp);
      end
    end
    {y, z} = 2'b00;
    for (int i = 0; i < 16; i++) begin
      step();
      total++;
      if (obs !== m_exp) begin
        bad++;
        $display("FAIL flash_exit i=%0d got=%b want=%b", i, obs, m_exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    {y, z} = 2'b00;
    apply_reset(0, "mid_rst0");
    while (!(m_phase == PH_EWG && m_elapsed == 2) && n < 100) begin
      step();
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL mid_reach_ewg got=%0d want<100", n);
    end
    apply_reset(3, "mid_rst");
    for (int i = 1; i <= 30; i++) begin
      step();
      total++;
      if (obs !== m_exp) begin
        bad++;
        $display("FAIL mid_resume edge=%0d got=%b want=%b", i, obs, m_exp);
      end
    end
  endtask

`ifdef TL_PED_EN
  task automatic test_ped();
    int n = 0;
    int walks = 0;
    {y, z} = 2'b00;
    apply_reset(0, "ped_rst");
    while (!(m_phase == PH_NSG && m_elapsed == 1) && n < 100) begin
      step();
      n++;
    end
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      walks += int'(walk);
      total++;
      if (obs !== m_exp) begin
        bad++;
        $display("FAIL ped i=%0d got=%b want=%b", i, obs, m_exp);
      end
    end
    total++;
    if (walks != GT) begin
      bad++;
      $display("FAIL ped_walk_len got=%0d want=%0d", walks, GT);
    end
  endtask
`endif

  task automatic test_random();
    {y, z} = 2'b00;
    apply_reset(0, "rand_rst");
    for (int i = 0; i < 1500; i++) begin
      step();
      total++;
      if (obs !== m_exp) begin
        bad++;
        $display("FAIL random i=%0d got=%b want=%b", i, obs, m_exp);
      end
      if ($urandom_range(29) == 0) {y, z} = 2'($urandom_range(3));
`ifdef TL_PED_EN
      ped_req = ($urandom_range(39) == 0);
`endif
    end
    ped_req = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_normal();
    test_mode11();
    test_flash();
    test_reset_mid();
`ifdef TL_PED_EN
    test_ped();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
